// File: rtl/bin2bcd_if.sv
// bin2bcd_if: start/busy/done handshake and result bus of the binary-to-BCD converter.
interface bin2bcd_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                             start;
    logic [BIN_W-1:0]                 bin_in;
    logic                             busy;
    logic                             done;
    logic [4*DIGITS-1:0]              bcd_out;
    logic                             neg;
    logic                             ovf;
    logic [$clog2(DIGITS+1)-1:0]      ndig;
    modport master (output start, bin_in, input busy, done, bcd_out, neg, ovf, ndig);
    modport slave  (input start, bin_in, output busy, done, bcd_out, neg, ovf, ndig);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter, one bit per clock,
// with optional two's-complement input, overflow flag and significant-digit count.
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3,
    parameter int SIGNED = 0
) (
    input logic      clk,
    input logic      rst,
    bin2bcd_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W);
    localparam int NW = $clog2(DIGITS + 1);

    typedef enum logic {IDLE, CONVERT} state_t;

    state_t           state, state_n;
    logic [BIN_W-1:0] sh, mag;
    logic [BW-1:0]    acc, adj, acc_n;
    logic [CW-1:0]    cnt;
    logic [NW-1:0]    nd_n;
    logic             ovt, sgn, is_neg, ovf_n, last;

    always_comb begin
        is_neg = (SIGNED != 0) && bus.bin_in[BIN_W-1];
        mag    = is_neg ? -bus.bin_in : bus.bin_in;
        adj    = '0;
        for (int k = 0; k < DIGITS; k++)
            adj[4*k +: 4] = (acc[4*k +: 4] >= 4'd5) ? acc[4*k +: 4] + 4'd3 : acc[4*k +: 4];
        acc_n = {adj[BW-2:0], sh[BIN_W-1]};
        // A bit leaving the top digit means the magnitude no longer fits in DIGITS digits.
        ovf_n = ovt | adj[BW-1];
        nd_n  = NW'(1);
        for (int k = 0; k < DIGITS; k++)
            if (acc_n[4*k +: 4] != 4'd0) nd_n = NW'(k + 1);
        last    = cnt == CW'(BIN_W - 1);
        state_n = state;
        if (state == IDLE && bus.start) state_n = CONVERT;
        else if (state == CONVERT && last) state_n = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh          <= '0;
            acc         <= '0;
            cnt         <= '0;
            ovt         <= 1'b0;
            sgn         <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.bcd_out <= '0;
            bus.neg     <= 1'b0;
            bus.ovf     <= 1'b0;
            bus.ndig    <= NW'(1);
        end else begin
            bus.done <= 1'b0;
            if (state == IDLE && bus.start) begin
                sh       <= mag;
                sgn      <= is_neg;
                acc      <= '0;
                ovt      <= 1'b0;
                cnt      <= '0;
                bus.busy <= 1'b1;
            end else if (state == CONVERT) begin
                acc <= acc_n;
                sh  <= {sh[BIN_W-2:0], 1'b0};
                ovt <= ovf_n;
                cnt <= cnt + 1'b1;
                if (last) begin
                    bus.bcd_out <= acc_n;
                    bus.neg     <= sgn;
                    bus.ovf     <= ovf_n;
                    bus.ndig    <= nd_n;
                    bus.done    <= 1'b1;
                    bus.busy    <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: four converter configurations checked every cycle against an
// arithmetic reference model, plus directed literal checks of key cases.
module tb_bin2bcd_seq;
    localparam int W [4] = '{8, 8, 8, 16};
    localparam int D [4] = '{3, 3, 2, 5};
    localparam int S [4] = '{0, 1, 0, 0};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic go  = 1'b0;
    always #5 clk = ~clk;

    logic        st [4];
    logic [31:0] bi [4];
    logic        bsy [4], dn [4], ng [4], ov [4];
    logic [39:0] bcd [4];
    int          nd [4];

    int tests = 0;
    int fails = 0;

    bin2bcd_if #(.BIN_W(8),  .DIGITS(3)) i0 ();
    bin2bcd_if #(.BIN_W(8),  .DIGITS(3)) i1 ();
    bin2bcd_if #(.BIN_W(8),  .DIGITS(2)) i2 ();
    bin2bcd_if #(.BIN_W(16), .DIGITS(5)) i3 ();

    bin2bcd_seq #(.BIN_W(8),  .DIGITS(3), .SIGNED(0)) u0 (.clk(clk), .rst(rst), .bus(i0));
    bin2bcd_seq #(.BIN_W(8),  .DIGITS(3), .SIGNED(1)) u1 (.clk(clk), .rst(rst), .bus(i1));
    bin2bcd_seq #(.BIN_W(8),  .DIGITS(2), .SIGNED(0)) u2 (.clk(clk), .rst(rst), .bus(i2));
    bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(0)) u3 (.clk(clk), .rst(rst), .bus(i3));

    assign i0.start = st[0]; assign i0.bin_in = bi[0][7:0];
    assign i1.start = st[1]; assign i1.bin_in = bi[1][7:0];
    assign i2.start = st[2]; assign i2.bin_in = bi[2][7:0];
    assign i3.start = st[3]; assign i3.bin_in = bi[3][15:0];

    assign bsy[0] = i0.busy; assign dn[0] = i0.done; assign ng[0] = i0.neg; assign ov[0] = i0.ovf;
    assign bsy[1] = i1.busy; assign dn[1] = i1.done; assign ng[1] = i1.neg; assign ov[1] = i1.ovf;
    assign bsy[2] = i2.busy; assign dn[2] = i2.done; assign ng[2] = i2.neg; assign ov[2] = i2.ovf;
    assign bsy[3] = i3.busy; assign dn[3] = i3.done; assign ng[3] = i3.neg; assign ov[3] = i3.ovf;
    assign bcd[0] = 40'(i0.bcd_out); assign nd[0] = int'(i0.ndig);
    assign bcd[1] = 40'(i1.bcd_out); assign nd[1] = int'(i1.ndig);
    assign bcd[2] = 40'(i2.bcd_out); assign nd[2] = int'(i2.ndig);
    assign bcd[3] = 40'(i3.bcd_out); assign nd[3] = int'(i3.ndig);

    // Decimal digits, sign, overflow and digit count straight from integer arithmetic.
    function automatic void ref_conv(input logic [31:0] raw, input int w, input int d, input int s,
                                     output logic [39:0] b, output logic n, output logic o,
                                     output int ndg);
        longint m, p, dig;
        m = longint'(raw) & ((longint'(1) << w) - 1);
        n = 1'b0;
        if (s != 0 && ((m >> (w - 1)) & 1) == 1) begin
            m = (longint'(1) << w) - m;
            n = 1'b1;
        end
        b   = '0;
        ndg = 1;
        p   = 1;
        for (int k = 0; k < d; k++) begin
            dig = (m / p) % 10;
            b[4*k +: 4] = 4'(dig);
            if (dig != 0) ndg = k + 1;
            p = p * 10;
        end
        o = m >= p;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Timing model: a conversion accepted at an edge completes W edges later.
    int          rem [4];
    logic [31:0] cap [4];
    logic [39:0] ebcd [4];
    logic        ebsy [4], edn [4], eng [4], eov [4];
    int          endg [4];
    logic [39:0] mb;
    logic        mn, mo;
    int          mk;

    initial for (int i = 0; i < 4; i++) begin
        rem[i] = 0; cap[i] = '0; ebcd[i] = '0; ebsy[i] = 1'b0; edn[i] = 1'b0;
        eng[i] = 1'b0; eov[i] = 1'b0; endg[i] = 1; st[i] = 1'b0; bi[i] = '0;
    end

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                rem[i] <= 0; ebsy[i] <= 1'b0; edn[i] <= 1'b0; ebcd[i] <= '0;
                eng[i] <= 1'b0; eov[i] <= 1'b0; endg[i] <= 1;
            end else begin
                edn[i] <= 1'b0;
                if (rem[i] == 0) begin
                    if (st[i]) begin
                        rem[i]  <= W[i];
                        cap[i]  <= bi[i];
                        ebsy[i] <= 1'b1;
                    end
                end else begin
                    rem[i] <= rem[i] - 1;
                    if (rem[i] == 1) begin
                        ref_conv(cap[i], W[i], D[i], S[i], mb, mn, mo, mk);
                        ebcd[i] <= mb; eng[i] <= mn; eov[i] <= mo; endg[i] <= mk;
                        edn[i]  <= 1'b1;
                        ebsy[i] <= 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (go && !rst) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("busy%0d", i), 64'(bsy[i]), 64'(ebsy[i]));
                chk($sformatf("done%0d", i), 64'(dn[i]), 64'(edn[i]));
                chk($sformatf("bcd%0d", i), 64'(bcd[i]), 64'(ebcd[i]));
                chk($sformatf("neg%0d", i), 64'(ng[i]), 64'(eng[i]));
                chk($sformatf("ovf%0d", i), 64'(ov[i]), 64'(eov[i]));
                chk($sformatf("ndig%0d", i), 64'(nd[i]), 64'(endg[i]));
            end
        end
    end

    // Starts a conversion on DUT i and waits (bounded) for its done pulse.
    task automatic conv(input int i, input logic [31:0] v, output int cyc, output int bc);
        st[i] = 1'b1;
        bi[i] = v;
        cyc = 0;
        bc  = 0;
        do begin
            @(negedge clk);
            cyc++;
            st[i] = 1'b0;
            if (bsy[i]) bc++;
        end while (!dn[i] && cyc < 200);
        chk($sformatf("done_seen%0d", i), 64'(dn[i]), 64'd1);
    endtask

    int          cyc, bc, dcnt, r;
    logic [39:0] got;

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", 64'(bsy[0]), 64'd0);
        chk("rst_done", 64'(dn[0]), 64'd0);
        chk("rst_bcd", 64'(bcd[0]), 64'd0);
        chk("rst_ndig", 64'(nd[0]), 64'd1);
        chk("rst_ndig16", 64'(nd[3]), 64'd1);
        rst = 1'b0;
        go  = 1'b1;
        @(negedge clk);

        conv(0, 255, cyc, bc);
        chk("lat255", 64'(cyc), 64'd9);
        chk("busy255", 64'(bc), 64'd8);
        chk("bcd255", 64'(bcd[0]), 64'h255);
        chk("ndig255", 64'(nd[0]), 64'd3);
        chk("ovf255", 64'(ov[0]), 64'd0);

        conv(0, 0, cyc, bc);
        chk("bcd0", 64'(bcd[0]), 64'h0);
        chk("ndig0", 64'(nd[0]), 64'd1);
        conv(0, 7, cyc, bc);
        chk("b2b_lat", 64'(cyc), 64'd9);
        chk("bcd7", 64'(bcd[0]), 64'h7);
        chk("ndig7", 64'(nd[0]), 64'd1);

        conv(1, 32'h80, cyc, bc);
        chk("s_bcd80", 64'(bcd[1]), 64'h128);
        chk("s_neg80", 64'(ng[1]), 64'd1);
        conv(1, 32'hFF, cyc, bc);
        chk("s_bcdff", 64'(bcd[1]), 64'h1);
        chk("s_negff", 64'(ng[1]), 64'd1);
        conv(1, 32'h7F, cyc, bc);
        chk("s_bcd7f", 64'(bcd[1]), 64'h127);
        chk("s_neg7f", 64'(ng[1]), 64'd0);

        conv(2, 100, cyc, bc);
        chk("d2_bcd100", 64'(bcd[2]), 64'h00);
        chk("d2_ovf100", 64'(ov[2]), 64'd1);
        conv(2, 99, cyc, bc);
        chk("d2_bcd99", 64'(bcd[2]), 64'h99);
        chk("d2_ovf99", 64'(ov[2]), 64'd0);
        chk("d2_ndig99", 64'(nd[2]), 64'd2);

        st[0] = 1'b1;
        bi[0] = 200;
        dcnt  = 0;
        got   = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            st[0] = (c >= 2 && c <= 6) ? 1'(c % 2) : 1'b0;
            bi[0] = $urandom;
            if (dn[0]) begin
                dcnt++;
                got = bcd[0];
            end
        end
        chk("tog_dones", 64'(dcnt), 64'd1);
        chk("tog_bcd", 64'(got), 64'h200);

        st[0] = 1'b1;
        bi[0] = 123;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_busy", 64'(bsy[0]), 64'd0);
        chk("arst_done", 64'(dn[0]), 64'd0);
        chk("arst_bcd", 64'(bcd[0]), 64'd0);
        chk("arst_ndig", 64'(nd[0]), 64'd1);
        @(negedge clk);
        rst  = 1'b0;
        dcnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (dn[0]) dcnt++;
        end
        chk("arst_nodone", 64'(dcnt), 64'd0);
        conv(0, 45, cyc, bc);
        chk("post_lat", 64'(cyc), 64'd9);
        chk("post_bcd", 64'(bcd[0]), 64'h45);
        chk("post_ndig", 64'(nd[0]), 64'd2);

        conv(3, 65535, cyc, bc);
        chk("w16_lat", 64'(cyc), 64'd17);
        chk("w16_bcd", 64'(bcd[3]), 64'h65535);
        chk("w16_ndig", 64'(nd[3]), 64'd5);

        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                st[i] = ($urandom_range(0, 2) == 0);
                r = int'($urandom_range(0, 3));
                bi[i] = (r == 0) ? 32'd0 : (r == 1) ? 32'hFFFF_FFFF :
                        (r == 2) ? (32'd1 << (W[i] - 1)) : $urandom;
            end
        end
        for (int i = 0; i < 4; i++) st[i] = 1'b0;
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
